// File: rtl/shift_unit_seq.sv
// shift_unit_seq: iterative SLL/SRL/SRA unit for the execute stage.
//
// Shifts one bit position per cycle (or four per cycle when the macro
// SHIFT_UNIT_RADIX4_EN is defined and at least four positions remain),
// trading latency for the area of a combinational barrel shifter.
//
// Ports:
//   clk     in   clock, rising edge
//   rst     in   synchronous active-high reset
//   start   in   request, sampled only while not busy
//   op      in   2'b00 SLL, 2'b01 SRL, 2'b11 SRA, 2'b10 illegal
//   a       in   operand (rs1)
//   shamt   in   shift amount
//   busy    out  shift in progress
//   done    out  one-cycle pulse, result valid
//   result  out  shift register contents, held outside SHIFT
//   illegal out  one-cycle pulse with done when op was 2'b10
module shift_unit_seq #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [DATA_W-1:0]  a,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [DATA_W-1:0]  result,
    output logic               illegal
);

    localparam logic [1:0] OpSll     = 2'b00;
    localparam logic [1:0] OpIllegal = 2'b10;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e               state_q, state_d;
    logic [DATA_W-1:0]    sreg_q, sreg_d;
    logic [SHAMT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]           op_q, op_d;
    logic                 sign_q, sign_d;

    // Fill bit for right shifts: sign only for SRA (op[1] set on a legal right shift).
    logic                 fill;
    assign fill = op_q[1] & sign_q;

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        sign_d  = sign_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StShift;
                    sreg_d  = a;
                    cnt_d   = shamt;
                    op_d    = op;
                    sign_d  = a[DATA_W-1];
                end else begin
                    state_d = StIdle;
                end
            end
            StShift: begin
                if (op_q == OpIllegal || cnt_q == '0) begin
                    state_d = StDone;
`ifdef SHIFT_UNIT_RADIX4_EN
                end else if (cnt_q >= SHAMT_W'(4)) begin
                    cnt_d = cnt_q - SHAMT_W'(4);
                    if (op_q == OpSll) begin
                        sreg_d = {sreg_q[DATA_W-5:0], 4'b0000};
                    end else begin
                        sreg_d = {{4{fill}}, sreg_q[DATA_W-1:4]};
                    end
`endif
                end else begin
                    cnt_d = cnt_q - SHAMT_W'(1);
                    if (op_q == OpSll) begin
                        sreg_d = {sreg_q[DATA_W-2:0], 1'b0};
                    end else begin
                        sreg_d = {fill, sreg_q[DATA_W-1:1]};
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            sreg_q  <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            sign_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            sign_q  <= sign_d;
        end
    end

    assign busy    = (state_q == StShift);
    assign done    = (state_q == StDone);
    assign illegal = done && (op_q == OpIllegal);
    assign result  = sreg_q;

endmodule
